// File: rtl/fire_ctrl_pkg.sv
// rtl/fire_ctrl_pkg.sv - shared states, mode constant and error codes for the fire-control sequencer
package fire_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FIRE     = 2'd1,
        ST_COOLDOWN = 2'd2,
        ST_RELOAD   = 2'd3
    } fc_state_e;

    localparam logic [3:0] ATTACK_MODE    = 4'b0010;

    localparam logic [1:0] ERR_WRONG_MODE = 2'b01;
    localparam logic [1:0] ERR_EMPTY      = 2'b10;
    localparam logic [1:0] ERR_RELOADING  = 2'b11;

    // Pointer width for a round-robin over n stations; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fire_ctrl_arbiter_rr.sv
// rtl/fire_ctrl_arbiter_rr.sv - combinational round-robin picker, search starts at rr_ptr
module rr_arbiter
    import fire_ctrl_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PTR_W = ptr_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] winner,
    output logic [PTR_W-1:0] winner_idx
);

    logic [PTR_W:0] pos;
    logic           found;

    // Walk the stations starting at rr_ptr (wrapping) and take the first requester.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        pos        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (pos >= (PTR_W+1)'(N_REQ)) begin
                pos = pos - (PTR_W+1)'(N_REQ);
            end
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && pos == (PTR_W+1)'(j) && req[j]) begin
                    found      = 1'b1;
                    winner[j]  = 1'b1;
                    winner_idx = PTR_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/fire_ctrl_arbiter.sv
// rtl/fire_ctrl_arbiter.sv - fire-control sequencer for the shared magazine; optional burst via FIRE_CTRL_BURST_EN
module fire_ctrl_arbiter
    import fire_ctrl_pkg::*;
#(
    parameter int                N_REQ   = 2,
    parameter int                AMMO_W  = 9,
    parameter int                CD_W    = 4,
    parameter logic [AMMO_W-1:0] MAG_MAX = AMMO_W'(300)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        mode,
    input  logic [N_REQ-1:0]  req,
    input  logic [AMMO_W-1:0] shot_cost,
    input  logic [CD_W-1:0]   cooldown,
    input  logic              reload_req,
    input  logic [AMMO_W-1:0] reload_step,
`ifdef FIRE_CTRL_BURST_EN
    input  logic [1:0]        burst_len,
`endif
    output logic [N_REQ-1:0]  grant,
    output logic              fire_pulse,
    output logic [AMMO_W-1:0] ammo_cnt,
    output logic              busy,
    output logic              error,
    output logic [1:0]        error_code
);

    localparam int PTR_W = ptr_width(N_REQ);

    fc_state_e         state;
    fc_state_e         state_d;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  win_idx;
    logic [CD_W-1:0]   cd_cnt;

    logic [N_REQ-1:0]  arb_winner;
    logic [PTR_W-1:0]  arb_idx;

    logic [AMMO_W-1:0] eff_cost;
    logic [AMMO_W-1:0] ammo_after;
    logic [AMMO_W:0]   reload_sum;
    logic [AMMO_W-1:0] reload_sat;
    logic [PTR_W:0]    ptr_inc;
    logic [PTR_W-1:0]  ptr_next;
    logic              burst_more;

    logic              grant_load;
    logic              reload_add;
    logic              cd_load;
    logic              err_set;
    logic [1:0]        err_code_d;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .winner     (arb_winner),
        .winner_idx (arb_idx)
    );

    // A zero cost still spends one round; reload sum is one bit wider so it cannot wrap.
    assign eff_cost   = (shot_cost == '0) ? AMMO_W'(1) : shot_cost;
    assign ammo_after = ammo_cnt - eff_cost;
    assign reload_sum = {1'b0, ammo_cnt} + {1'b0, reload_step};
    assign reload_sat = (reload_sum >= {1'b0, MAG_MAX}) ? MAG_MAX : reload_sum[AMMO_W-1:0];
    assign ptr_inc    = {1'b0, win_idx} + (PTR_W+1)'(1);
    assign ptr_next   = (ptr_inc >= (PTR_W+1)'(N_REQ)) ? '0 : ptr_inc[PTR_W-1:0];

    assign fire_pulse = (state == ST_FIRE);
    assign busy       = (state != ST_IDLE);

`ifdef FIRE_CTRL_BURST_EN
    logic [1:0] burst_rem;

    // Shots still owed in the current burst; loaded with the grant, spent one per FIRE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_rem <= 2'd0;
        end else if (grant_load) begin
            burst_rem <= burst_len;
        end else if (state == ST_FIRE && burst_rem != 2'd0) begin
            burst_rem <= burst_rem - 2'd1;
        end
    end

    assign burst_more = (burst_rem != 2'd0) && (ammo_after >= eff_cost);
`else
    assign burst_more = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and datapath control; reload outranks a fire request in IDLE.
    always_comb begin
        state_d    = state;
        grant_load = 1'b0;
        reload_add = 1'b0;
        cd_load    = 1'b0;
        err_set    = 1'b0;
        err_code_d = '0;
        case (state)
            ST_IDLE: begin
                if (reload_req && ammo_cnt < MAG_MAX) begin
                    state_d = ST_RELOAD;
                end else if (|req) begin
                    if (mode != ATTACK_MODE) begin
                        err_set    = 1'b1;
                        err_code_d = ERR_WRONG_MODE;
                    end else if (ammo_cnt < eff_cost) begin
                        err_set    = 1'b1;
                        err_code_d = ERR_EMPTY;
                    end else begin
                        grant_load = 1'b1;
                        state_d    = ST_FIRE;
                    end
                end
            end
            ST_FIRE: begin
                if (burst_more) begin
                    state_d = ST_FIRE;
                end else if (cooldown == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cd_load = 1'b1;
                    state_d = ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                if (cd_cnt <= CD_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RELOAD: begin
                if (|req) begin
                    err_set    = 1'b1;
                    err_code_d = ERR_RELOADING;
                end
                if (!reload_req) begin
                    state_d = ST_IDLE;
                end else begin
                    reload_add = 1'b1;
                    if (reload_sat == MAG_MAX) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Magazine count, grant, pointer, cooldown counter and error strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ammo_cnt   <= '0;
            grant      <= '0;
            rr_ptr     <= '0;
            win_idx    <= '0;
            cd_cnt     <= '0;
            error      <= 1'b0;
            error_code <= '0;
        end else begin
            error <= err_set;
            if (err_set) begin
                error_code <= err_code_d;
            end

            if (grant_load) begin
                grant   <= arb_winner;
                win_idx <= arb_idx;
            end else if (state == ST_FIRE && state_d != ST_FIRE) begin
                grant <= '0;
            end

            if (state == ST_FIRE) begin
                ammo_cnt <= ammo_after;
                rr_ptr   <= ptr_next;
            end else if (reload_add) begin
                ammo_cnt <= reload_sat;
            end

            if (cd_load) begin
                cd_cnt <= cooldown;
            end else if (state == ST_COOLDOWN) begin
                cd_cnt <= cd_cnt - CD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fire_ctrl_arbiter.sv
// tb/tb_fire_ctrl_arbiter.sv - directed bench with a cycle model of the fire-control rules
module tb_fire_ctrl_arbiter;

    localparam int N_REQ = 2;
    localparam int MAG   = 300;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] mode;
    logic [1:0] req;
    logic [8:0] shot_cost;
    logic [3:0] cooldown;
    logic       reload_req;
    logic [8:0] reload_step;
    logic [1:0] grant;
    logic       fire_pulse;
    logic [8:0] ammo_cnt;
    logic       busy;
    logic       error;
    logic [1:0] error_code;
`ifdef FIRE_CTRL_BURST_EN
    logic [1:0] burst_len = 2'd0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fire_ctrl_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .req         (req),
        .shot_cost   (shot_cost),
        .cooldown    (cooldown),
        .reload_req  (reload_req),
        .reload_step (reload_step),
`ifdef FIRE_CTRL_BURST_EN
        .burst_len   (burst_len),
`endif
        .grant       (grant),
        .fire_pulse  (fire_pulse),
        .ammo_cnt    (ammo_cnt),
        .busy        (busy),
        .error       (error),
        .error_code  (error_code)
    );

    // Model: a shot in flight, cycles of cooldown left, a reload in progress, or idle.
    int         m_ammo = 0;
    int         m_ptr  = 0;
    int         m_cool = 0;
    int         m_win  = 0;
    int         m_code = 0;
    bit         m_firing = 1'b0;
    bit         m_reload = 1'b0;
    bit         m_err    = 1'b0;
    logic [1:0] m_grant  = 2'b00;
    logic       m_busy;

    assign m_busy = m_firing || (m_cool > 0) || m_reload;

    always @(posedge clk or negedge rst_n) begin
        int a, p, c, w, code, cost;
        bit f, r, e;
        logic [1:0] g;
        if (!rst_n) begin
            m_ammo <= 0; m_ptr <= 0; m_cool <= 0; m_win <= 0; m_code <= 0;
            m_firing <= 1'b0; m_reload <= 1'b0; m_err <= 1'b0; m_grant <= 2'b00;
        end else begin
            a = m_ammo; p = m_ptr; c = m_cool; w = m_win; code = m_code;
            f = m_firing; r = m_reload; e = 1'b0; g = m_grant;
            cost = (shot_cost == 0) ? 1 : int'(shot_cost);
            if (f) begin
                a = a - cost;
                p = (w + 1) % N_REQ;
                f = 1'b0;
                g = 2'b00;
                c = int'(cooldown);
            end else if (c > 0) begin
                c = c - 1;
            end else if (r) begin
                if (req != 0) begin
                    e = 1'b1; code = 3;
                end
                if (!reload_req) begin
                    r = 1'b0;
                end else begin
                    a = a + int'(reload_step);
                    if (a >= MAG) begin
                        a = MAG; r = 1'b0;
                    end
                end
            end else if (reload_req && a < MAG) begin
                r = 1'b1;
            end else if (req != 0) begin
                if (mode != 4'd2) begin
                    e = 1'b1; code = 1;
                end else if (a < cost) begin
                    e = 1'b1; code = 2;
                end else begin
                    for (int k = N_REQ - 1; k >= 0; k--) begin
                        if (req[(p + k) % N_REQ]) w = (p + k) % N_REQ;
                    end
                    g = 2'b00;
                    g[w] = 1'b1;
                    f = 1'b1;
                end
            end
            m_ammo <= a; m_ptr <= p; m_cool <= c; m_win <= w; m_code <= code;
            m_firing <= f; m_reload <= r; m_err <= e; m_grant <= g;
        end
    end

    // Every falling edge: all outputs against the model.
    always @(negedge clk) begin
        n_cmp++;
        if ({grant, fire_pulse, ammo_cnt, busy, error, error_code} !==
            {m_grant, m_firing, 9'(m_ammo), m_busy, m_err, 2'(m_code)}) begin
            n_bad++;
            $display("FAIL cycle_cmp t=%0t actual grant=%b fire=%b ammo=%0d busy=%b err=%b code=%b required grant=%b fire=%b ammo=%0d busy=%b err=%b code=%b",
                     $time, grant, fire_pulse, ammo_cnt, busy, error, error_code,
                     m_grant, m_firing, m_ammo, m_busy, m_err, 2'(m_code));
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fire(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (fire_pulse) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(name, int'(ok), 1);
    endtask

    initial begin
        rst_n = 1'b0; mode = 4'd0; req = 2'b00; shot_cost = 9'd0; cooldown = 4'd0;
        reload_req = 1'b0; reload_step = 9'd0;
        tick(); tick();
        chk("rst_ammo", ammo_cnt, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        rst_n = 1'b1;
        tick();

        // Reload from empty, landing exactly on the ceiling.
        reload_req = 1'b1; reload_step = 9'd100;
        tick();
        tick(); chk("reload_100", ammo_cnt, 100);
        tick(); chk("reload_200", ammo_cnt, 200);
        tick(); chk("reload_300", ammo_cnt, 300);
        chk("reload_exit_busy", busy, 0);
        tick(); chk("reload_full_hold", ammo_cnt, 300);
        reload_req = 1'b0;

        // Two stations, round robin with cooldown between shots.
        mode = 4'd2; shot_cost = 9'd9; cooldown = 4'd2; req = 2'b11;
        wait_fire("fire1_seen");
        chk("fire1_grant", grant, 1);
        tick(); chk("fire1_ammo", ammo_cnt, 291);
        wait_fire("fire2_seen");
        chk("fire2_grant", grant, 2);
        tick(); chk("fire2_ammo", ammo_cnt, 282);
        req = 2'b00;
        tick(); tick(); tick();

        // Wrong mode: error every offending cycle, code held afterwards.
        mode = 4'd1; req = 2'b01;
        tick(); chk("wm_error", error, 1); chk("wm_code", error_code, 1); chk("wm_grant", grant, 0);
        tick(); chk("wm_error_again", error, 1);
        req = 2'b00;
        tick(); chk("wm_error_clear", error, 0); chk("wm_code_hold", error_code, 1);
        chk("wm_ammo", ammo_cnt, 282);

        // Not enough ammo for the shot.
        mode = 4'd2; shot_cost = 9'd300; req = 2'b01;
        tick(); chk("empty_error", error, 1); chk("empty_code", error_code, 2); chk("empty_nofire", fire_pulse, 0);
        req = 2'b00;
        tick();

        // Zero cost spends one round; zero cooldown returns straight to idle.
        shot_cost = 9'd0; cooldown = 4'd0; req = 2'b01;
        wait_fire("cost0_seen");
        chk("cost0_grant", grant, 1);
        req = 2'b00;
        tick(); chk("cost0_ammo", ammo_cnt, 281); chk("cost0_idle", busy, 0);

        // Request during reload, then reload dropped mid-way.
        shot_cost = 9'd9; reload_req = 1'b1; reload_step = 9'd3;
        tick();
        tick(); chk("rl_284", ammo_cnt, 284);
        req = 2'b01;
        tick(); chk("rl_287", ammo_cnt, 287); chk("rl_err", error, 1); chk("rl_code", error_code, 3);
        req = 2'b00; reload_req = 1'b0;
        tick(); chk("rl_drop_ammo", ammo_cnt, 287); chk("rl_drop_idle", busy, 0);
        tick(); chk("rl_frozen", ammo_cnt, 287);

        // Overshoot that would wrap a 9-bit sum saturates instead.
        reload_req = 1'b1; reload_step = 9'd250;
        tick();
        tick(); chk("sat_300", ammo_cnt, 300); chk("sat_idle", busy, 0);
        reload_req = 1'b0;
        tick();

        // Reset during cooldown clears everything, including the pointer.
        cooldown = 4'd5; req = 2'b01;
        wait_fire("cd_fire_seen");
        chk("cd_fire_grant", grant, 1);
        tick(); req = 2'b00;
        tick(); chk("cd_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_fire", fire_pulse, 0);
        chk("mid_rst_ammo", ammo_cnt, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_code", error_code, 0);
        tick();
        rst_n = 1'b1; reload_req = 1'b1; reload_step = 9'd100;
        tick();
        tick(); chk("post_rst_reload", ammo_cnt, 100);
        reload_req = 1'b0;
        tick();
        req = 2'b11;
        wait_fire("post_rst_fire_seen");
        chk("post_rst_grant", grant, 1);
        req = 2'b00;
        tick(); chk("post_rst_ammo", ammo_cnt, 91);
        for (int i = 0; i < 8; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
